// File: rtl/dsi_pkg.sv
// Shared DSI packet constants, packetizer FSM encoding and the header ECC function.
package dsi_pkg;

    localparam logic [5:0] DT_VSS    = 6'h01;
    localparam logic [5:0] DT_HSS    = 6'h21;
    localparam logic [5:0] DT_RGB888 = 6'h3E;

    typedef logic [2:0] dsi_state_t;
    localparam dsi_state_t ST_IDLE    = 3'd0;
    localparam dsi_state_t ST_SYNC    = 3'd1;
    localparam dsi_state_t ST_HDR     = 3'd2;
    localparam dsi_state_t ST_PAYLOAD = 3'd3;
    localparam dsi_state_t ST_FOOTER  = 3'd4;

    // Hamming parity over the 24 header bits {WC/data1, data0, DI}; top two bits are always zero.
    function automatic logic [7:0] dsi_ecc(input logic [23:0] d);
        logic [5:0] p;
        p[0] = d[0] ^ d[1] ^ d[2] ^ d[4] ^ d[5] ^ d[7] ^ d[10] ^ d[11] ^ d[13] ^ d[16] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
        p[1] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8] ^ d[10] ^ d[12] ^ d[14] ^ d[17] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
        p[2] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9] ^ d[11] ^ d[12] ^ d[15] ^ d[18] ^ d[20] ^ d[21] ^ d[22];
        p[3] = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9] ^ d[13] ^ d[14] ^ d[15] ^ d[19] ^ d[20] ^ d[21] ^ d[23];
        p[4] = d[4] ^ d[5] ^ d[6] ^ d[7] ^ d[8] ^ d[9] ^ d[16] ^ d[17] ^ d[18] ^ d[19] ^ d[20] ^ d[22] ^ d[23];
        p[5] = d[10] ^ d[11] ^ d[12] ^ d[13] ^ d[14] ^ d[15] ^ d[16] ^ d[17] ^ d[18] ^ d[19] ^ d[21] ^ d[22] ^ d[23];
        return {2'b00, p};
    endfunction

endpackage

// File: rtl/dsi_header_ecc.sv
// Combinational DSI packet-header ECC; zero latency, no flow control.
module dsi_header_ecc
    import dsi_pkg::*;
(
    input  logic [23:0] hdr,
    output logic [7:0]  ecc
);

    assign ecc = dsi_ecc(hdr);

endmodule

// File: rtl/dsi_line_packetizer.sv
// Turns a show-ahead RGB888 pixel FIFO into per-line DSI packets (sync, header, payload, footer).
// One registered output word, one word per cycle; holds while out_ready is low, gaps when the FIFO runs dry.
module dsi_line_packetizer
    import dsi_pkg::*;
#(
    parameter logic [7:0] DATA_TYPE      = {2'b00, DT_RGB888},
    parameter int         FIFO_SHOWAHEAD = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        pix_fifo_read,
    input  logic [31:0] pix_fifo_data,
    input  logic        pix_fifo_empty,
    input  logic        enable,
    input  logic [15:0] line_pixels,
    input  logic [15:0] frame_lines,
    input  logic [1:0]  virtual_channel,
    output logic [31:0] out_data,
    output logic [3:0]  out_strb,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        underflow,
    output logic        frame_done,
    output logic        active
);

    localparam logic SHOWAHEAD_OK = (FIFO_SHOWAHEAD == 1);

    dsi_state_t  state_q, state_d;
    logic [15:0] word_cnt_q, word_cnt_d;
    logic [15:0] line_cnt_q, line_cnt_d;
    logic [15:0] lp_q, lp_d;
    logic [15:0] fl_q, fl_d;
    logic [1:0]  vc_q, vc_d;
    logic [31:0] out_data_q, out_data_d;
    logic [3:0]  out_strb_q, out_strb_d;
    logic        out_valid_q, out_valid_d;
    logic        underflow_q, underflow_d;
    logic        frame_done_q, frame_done_d;
    logic        last_ftr_q, last_ftr_d;

    logic        load;
    logic        first_line;
    logic        last_line;
    logic        last_word;
    logic [15:0] wc;
    logic [15:0] n_words;
    logic [7:0]  di;
    logic [23:0] hdr;
    logic [7:0]  ecc;

    assign load       = !out_valid_q || out_ready;
    assign wc         = lp_q + {lp_q[14:0], 1'b0};
    // line_pixels is a multiple of 4, so the payload is exactly 3 words per 4 pixels.
    assign n_words    = {2'b00, lp_q[15:2]} + {1'b0, lp_q[15:2], 1'b0};
    assign first_line = (line_cnt_q == 16'd0);
    assign last_line  = (line_cnt_q == fl_q - 16'd1);
    assign last_word  = (word_cnt_q == n_words - 16'd1);

    assign di  = (state_q == ST_SYNC) ? {vc_q, (first_line ? DT_VSS : DT_HSS)} : {vc_q, DATA_TYPE[5:0]};
    assign hdr = (state_q == ST_SYNC) ? {16'h0000, di} : {wc, di};

    dsi_header_ecc u_header_ecc (
        .hdr (hdr),
        .ecc (ecc)
    );

    always_comb begin
        state_d       = state_q;
        word_cnt_d    = word_cnt_q;
        line_cnt_d    = line_cnt_q;
        lp_d          = lp_q;
        fl_d          = fl_q;
        vc_d          = vc_q;
        out_data_d    = out_data_q;
        out_strb_d    = out_strb_q;
        out_valid_d   = out_valid_q;
        underflow_d   = underflow_q;
        last_ftr_d    = last_ftr_q;
        pix_fifo_read = 1'b0;
        frame_done_d  = out_valid_q && out_ready && last_ftr_q;

        // A load slot empties the register unless a state below fills it.
        if (load) begin
            out_valid_d = 1'b0;
            last_ftr_d  = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d    = ST_SYNC;
                    lp_d       = line_pixels;
                    fl_d       = frame_lines;
                    vc_d       = virtual_channel;
                    line_cnt_d = 16'd0;
                    word_cnt_d = 16'd0;
                end
            end
            ST_SYNC, ST_HDR: begin
                if (load) begin
                    out_data_d  = {ecc, hdr};
                    out_strb_d  = 4'hF;
                    out_valid_d = 1'b1;
                    state_d     = (state_q == ST_SYNC) ? ST_HDR : ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (load && (word_cnt_q < n_words)) begin
                    if (pix_fifo_empty) begin
                        underflow_d = 1'b1;
                    end else if (SHOWAHEAD_OK) begin
                        pix_fifo_read = 1'b1;
                        out_data_d    = pix_fifo_data;
                        out_strb_d    = 4'hF;
                        out_valid_d   = 1'b1;
                        word_cnt_d    = word_cnt_q + 16'd1;
                        if (last_word) state_d = ST_FOOTER;
                    end
                end
            end
            ST_FOOTER: begin
                if (load) begin
                    out_data_d  = 32'h0000_0000;
                    out_strb_d  = 4'b0011;
                    out_valid_d = 1'b1;
                    last_ftr_d  = last_line;
                    if (!enable) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d    = ST_SYNC;
                        word_cnt_d = 16'd0;
                        if (last_line) begin
                            line_cnt_d = 16'd0;
                            lp_d       = line_pixels;
                            fl_d       = frame_lines;
                            vc_d       = virtual_channel;
                        end else begin
                            line_cnt_d = line_cnt_q + 16'd1;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (!enable && (state_q == ST_IDLE)) underflow_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            word_cnt_q   <= 16'd0;
            line_cnt_q   <= 16'd0;
            lp_q         <= 16'd0;
            fl_q         <= 16'd0;
            vc_q         <= 2'd0;
            out_data_q   <= 32'd0;
            out_strb_q   <= 4'd0;
            out_valid_q  <= 1'b0;
            underflow_q  <= 1'b0;
            frame_done_q <= 1'b0;
            last_ftr_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_cnt_q   <= word_cnt_d;
            line_cnt_q   <= line_cnt_d;
            lp_q         <= lp_d;
            fl_q         <= fl_d;
            vc_q         <= vc_d;
            out_data_q   <= out_data_d;
            out_strb_q   <= out_strb_d;
            out_valid_q  <= out_valid_d;
            underflow_q  <= underflow_d;
            frame_done_q <= frame_done_d;
            last_ftr_q   <= last_ftr_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_strb   = out_strb_q;
    assign out_valid  = out_valid_q;
    assign underflow  = underflow_q;
    assign frame_done = frame_done_q;
    assign active     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dsi_line_packetizer.sv
// Bench for dsi_line_packetizer: table of single-line frames, directed corner cases and random frames.
module tb_dsi_line_packetizer;

    logic        clk;
    logic        rst_n;
    logic        pix_fifo_read;
    logic [31:0] pix_fifo_data;
    logic        pix_fifo_empty;
    logic        enable;
    logic [15:0] line_pixels;
    logic [15:0] frame_lines;
    logic [1:0]  virtual_channel;
    logic [31:0] out_data;
    logic [3:0]  out_strb;
    logic        out_valid;
    logic        out_ready;
    logic        underflow;
    logic        frame_done;
    logic        active;

    dsi_line_packetizer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pix_fifo_read   (pix_fifo_read),
        .pix_fifo_data   (pix_fifo_data),
        .pix_fifo_empty  (pix_fifo_empty),
        .enable          (enable),
        .line_pixels     (line_pixels),
        .frame_lines     (frame_lines),
        .virtual_channel (virtual_channel),
        .out_data        (out_data),
        .out_strb        (out_strb),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .underflow       (underflow),
        .frame_done      (frame_done),
        .active          (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Syndrome column of each header bit: the ECC is the XOR of the columns of all set bits.
    localparam logic [5:0] COL_CODE [0:23] = '{
        6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
        6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
        6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};

    typedef struct {
        int          vc;
        int          lp;
        logic [31:0] sync_w;
        logic [31:0] hdr_w;
    } vec_t;

    vec_t        vecs [4];
    int          n_cmp, n_bad;
    logic [31:0] fifo_q [$];
    logic [35:0] got_q [$];
    logic        hold_empty;
    logic        prev_stall;
    logic [35:0] prev_word;
    logic        uf_prev, uf_seen;
    int          pops, fd_cnt, rd_bad, uf_fall, gap_cnt;

    function automatic logic [31:0] ref_short(input logic [7:0] di, input logic [15:0] wc);
        logic [23:0] d;
        logic [5:0]  e;
        d = {wc, di};
        e = 6'h00;
        for (int i = 0; i < 24; i++) if (d[i]) e = e ^ COL_CODE[i];
        return {2'b00, e, d};
    endfunction

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic refresh();
        pix_fifo_empty = hold_empty || (fifo_q.size() == 0);
        pix_fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
    endtask

    // Called at a falling edge with inputs set; observes what the next rising edge commits.
    task automatic step();
        logic        do_pop;
        logic [31:0] dummy;
        do_pop = 1'b0;
        refresh();
        #1;
        if (prev_stall)
            chk("stall_hold", {3'b000, out_valid, out_strb, out_data}, {4'b0001, prev_word});
        if (out_valid && !out_ready)
            chk("stall_no_read", {39'd0, pix_fifo_read}, 40'd0);
        if (out_valid && out_ready) got_q.push_back({out_strb, out_data});
        if (pix_fifo_read) begin
            if (pix_fifo_empty) rd_bad++;
            else do_pop = 1'b1;
        end
        if (frame_done) fd_cnt++;
        if (underflow) uf_seen = 1'b1;
        if (uf_prev && !underflow && active) uf_fall++;
        uf_prev = underflow;
        if (got_q.size() != 0 && active && !out_valid) gap_cnt++;
        prev_stall = out_valid && !out_ready;
        prev_word  = {out_strb, out_data};
        @(posedge clk);
        @(negedge clk);
        if (do_pop) begin
            dummy = fifo_q.pop_front();
            pops++;
        end
    endtask

    // Runs one frame; enable drops once the sync word of line 'last_line' is accepted.
    task automatic run(input int lp, input int fl, input int vc, input int last_line,
                       input int stall_at, input int gap_at, input bit rnd_rdy);
        logic [35:0] exp_q [$];
        logic [31:0] w;
        int nw, nl, drop_idx, budget, stall_left, gap_left;
        bit stall_done, gap_done;
        nw = lp * 3 / 4;
        nl = last_line + 1;
        fifo_q.delete();
        got_q.delete();
        for (int l = 0; l < nl; l++) begin
            exp_q.push_back({4'hF, ref_short({vc[1:0], (l == 0) ? 6'h01 : 6'h21}, 16'h0000)});
            exp_q.push_back({4'hF, ref_short({vc[1:0], 6'h3E}, 16'(lp * 3))});
            for (int i = 0; i < nw; i++) begin
                w = $urandom;
                fifo_q.push_back(w);
                exp_q.push_back({4'hF, w});
            end
            exp_q.push_back({4'h3, 32'h0});
        end
        pops = 0; fd_cnt = 0; rd_bad = 0; uf_fall = 0; gap_cnt = 0;
        uf_prev = underflow; uf_seen = 1'b0; prev_stall = 1'b0;
        stall_left = 0; gap_left = 0; stall_done = 0; gap_done = 0;
        drop_idx = last_line * (nw + 3) + 1;
        line_pixels = 16'(lp); frame_lines = 16'(fl); virtual_channel = vc[1:0];
        enable = 1'b1;
        for (budget = 0; budget < 5000; budget++) begin
            if (enable && got_q.size() >= drop_idx) enable = 1'b0;
            if (stall_at >= 0 && !stall_done && got_q.size() == stall_at) begin
                stall_left = 5; stall_done = 1;
            end
            if (gap_at >= 0 && !gap_done && got_q.size() == gap_at) begin
                gap_left = 3; gap_done = 1;
            end
            out_ready = (stall_left > 0) ? 1'b0 : (rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1);
            hold_empty = (gap_left > 0);
            if (stall_left > 0) stall_left--;
            if (gap_left > 0) gap_left--;
            step();
            if (!enable && !active && !out_valid) break;
        end
        out_ready = 1'b1;
        hold_empty = 1'b0;
        step();
        chk("run_timeout", {39'd0, budget >= 5000}, 40'd0);
        chk("word_count", 40'(got_q.size()), 40'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("word[%0d]", i), (i < got_q.size()) ? {4'h0, got_q[i]} : 40'hFF_FFFF_FFFF, {4'h0, exp_q[i]});
        chk("fifo_pops", 40'(pops), 40'(nw * nl));
        chk("read_while_empty", 40'(rd_bad), 40'd0);
        chk("frame_done_count", 40'(fd_cnt), (last_line == fl - 1) ? 40'd1 : 40'd0);
        chk("valid_gap", {39'd0, gap_cnt != 0}, {39'd0, gap_at >= 0});
        chk("underflow_seen", {39'd0, uf_seen}, {39'd0, gap_at >= 0});
        chk("underflow_fell_early", 40'(uf_fall), 40'd0);
        chk("underflow_cleared", {39'd0, underflow}, 40'd0);
        chk("idle_after_run", {39'd0, active}, 40'd0);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        rst_n = 1'b0; enable = 1'b0; out_ready = 1'b1; hold_empty = 1'b0;
        line_pixels = 16'd0; frame_lines = 16'd0; virtual_channel = 2'd0;
        prev_stall = 1'b0; prev_word = '0; uf_prev = 1'b0; uf_seen = 1'b0;
        pops = 0; fd_cnt = 0; rd_bad = 0; uf_fall = 0; gap_cnt = 0;
        refresh();

        vecs[0] = '{0, 4,  32'h07000001, 32'h08000C3E};
        vecs[1] = '{1, 4,  32'h11000041, 32'h1E000C7E};
        vecs[2] = '{2, 8,  32'h1E000081, 32'h140018BE};
        vecs[3] = '{3, 20, 32'h080000C1, 32'h08003CFE};

        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", {39'd0, out_valid}, 40'd0);
        chk("rst_out_data", {8'd0, out_data}, 40'd0);
        chk("rst_out_strb", {36'd0, out_strb}, 40'd0);
        chk("rst_active", {39'd0, active}, 40'd0);
        chk("rst_underflow", {39'd0, underflow}, 40'd0);
        chk("rst_frame_done", {39'd0, frame_done}, 40'd0);
        chk("rst_fifo_read", {39'd0, pix_fifo_read}, 40'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            run(vecs[v].lp, 1, vecs[v].vc, 0, -1, -1, 1'b0);
            chk($sformatf("vec%0d_sync", v), (got_q.size() > 0) ? {4'h0, got_q[0]} : 40'hFF_FFFF_FFFF, {8'h0F, vecs[v].sync_w});
            chk($sformatf("vec%0d_hdr", v), (got_q.size() > 1) ? {4'h0, got_q[1]} : 40'hFF_FFFF_FFFF, {8'h0F, vecs[v].hdr_w});
        end

        // Two-line frame: second line opens with HSS.
        run(8, 2, 0, 1, -1, -1, 1'b0);
        chk("hss_word", (got_q.size() > 9) ? {4'h0, got_q[9]} : 40'hFF_FFFF_FFFF, 40'h0F_1200_0021);

        // Backpressure mid-payload, then a FIFO dry spell mid-payload.
        run(40, 1, 1, 0, 8, -1, 1'b0);
        run(40, 1, 2, 0, -1, 6, 1'b0);

        // Enable dropped during line 0 of a 3-line frame.
        run(8, 3, 0, 0, -1, -1, 1'b0);

        // Reset while the sync word is presented and the FSM sits in HDR.
        fifo_q.delete();
        for (int i = 0; i < 3; i++) fifo_q.push_back($urandom);
        line_pixels = 16'd4; frame_lines = 16'd1; virtual_channel = 2'd0;
        enable = 1'b1; out_ready = 1'b1; hold_empty = 1'b0;
        got_q.delete();
        for (int i = 0; i < 20 && !out_valid; i++) step();
        chk("pre_reset_valid", {39'd0, out_valid}, 40'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {39'd0, out_valid}, 40'd0);
        chk("arst_out_data", {8'd0, out_data}, 40'd0);
        chk("arst_out_strb", {36'd0, out_strb}, 40'd0);
        chk("arst_active", {39'd0, active}, 40'd0);
        chk("arst_fifo_read", {39'd0, pix_fifo_read}, 40'd0);
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        prev_stall = 1'b0;
        @(negedge clk);
        run(4, 1, 0, 0, -1, -1, 1'b0);

        // Random frames, random backpressure, random truncation.
        for (int r = 0; r < 8; r++) begin
            int lp, fl;
            lp = 4 * $urandom_range(1, 16);
            fl = $urandom_range(1, 3);
            run(lp, fl, $urandom_range(0, 3), $urandom_range(0, fl - 1), -1, -1, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
